// File: rtl/mult_req_sequencer.sv
// Operand FIFO plus req/ack sequencer for the signed 16x16 multiplier.
// One multiplier transaction in flight; results leave on a valid/ready stream with a status code.
module mult_req_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [1:0]  in_par_inv,
    output logic [15:0] arg_a,
    output logic [15:0] arg_b,
    output logic        arg_a_parity,
    output logic        arg_b_parity,
    output logic        req,
    input  logic        ack,
    input  logic [31:0] result,
    input  logic        result_parity,
    input  logic        arg_parity_error,
    input  logic        result_rdy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [1:0]  res_status,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [WW-1:0] WD_ONE  = 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RES, OUT} state_t;

    state_t         state_q;
    logic [33:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           empty, full, push, pop;
    logic [33:0]    head;
    logic [WW-1:0]  wdog_q;
    logic [15:0]    arg_a_q, arg_b_q;
    logic           arg_a_par_q, arg_b_par_q, req_q, res_valid_q;
    logic [31:0]    res_data_q;
    logic [1:0]     res_status_q;
    logic [1:0]     cap_status;
    logic [31:0]    cap_data;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign pop      = (state_q == IDLE) & ~empty;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_par_inv, in_b, in_a};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Arg parity error outranks a result parity mismatch.
    always_comb begin
        cap_status = 2'b00;
        cap_data   = result;
        if (arg_parity_error) begin
            cap_status = 2'b01;
            cap_data   = '0;
        end else if (result_parity != ^result) begin
            cap_status = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wdog_q       <= '0;
            arg_a_q      <= '0;
            arg_b_q      <= '0;
            arg_a_par_q  <= 1'b0;
            arg_b_par_q  <= 1'b0;
            req_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        arg_a_q     <= head[15:0];
                        arg_b_q     <= head[31:16];
                        arg_a_par_q <= ^head[15:0] ^ head[32];
                        arg_b_par_q <= ^head[31:16] ^ head[33];
                        req_q       <= 1'b1;
                        wdog_q      <= '0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    wdog_q <= wdog_q + WD_ONE;
                    if (wdog_q == WD_LAST) begin
                        req_q        <= 1'b0;
                        res_status_q <= 2'b11;
                        res_data_q   <= '0;
                        res_valid_q  <= 1'b1;
                        state_q      <= OUT;
                    end else if (ack) begin
                        req_q <= 1'b0;
                        if (result_rdy) begin
                            res_status_q <= cap_status;
                            res_data_q   <= cap_data;
                            res_valid_q  <= 1'b1;
                            state_q      <= OUT;
                        end else begin
                            state_q <= WAIT_RES;
                        end
                    end
                end
                WAIT_RES: begin
                    wdog_q <= wdog_q + WD_ONE;
                    if (wdog_q == WD_LAST) begin
                        res_status_q <= 2'b11;
                        res_data_q   <= '0;
                        res_valid_q  <= 1'b1;
                        state_q      <= OUT;
                    end else if (result_rdy) begin
                        res_status_q <= cap_status;
                        res_data_q   <= cap_data;
                        res_valid_q  <= 1'b1;
                        state_q      <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arg_a        = arg_a_q;
    assign arg_b        = arg_b_q;
    assign arg_a_parity = arg_a_par_q;
    assign arg_b_parity = arg_b_par_q;
    assign req          = req_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_status   = res_status_q;
    assign busy         = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_mult_req_sequencer.sv
// Scoreboard bench for mult_req_sequencer with a behavioural multiplier on the far side.
module tb_mult_req_sequencer;
    localparam int M_OK = 0, M_BADPAR = 1, M_NOACK = 2, M_SLOW = 3;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  inv;
        int          mode;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic [1:0]  in_par_inv;
    logic [15:0] arg_a, arg_b;
    logic        arg_a_parity, arg_b_parity, req, ack;
    logic [31:0] result;
    logic        result_parity, arg_parity_error, result_rdy;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_status;
    logic        busy;

    int          n_vec = 0, n_err = 0, n_res = 0;
    int          rr_mode = 1;
    int          req_len = 0;
    logic [31:0] last_data = '0;
    logic [1:0]  last_status = '0;
    txn_t        arg_q[$];
    logic [33:0] res_q[$];

    always #5 clk = ~clk;

    mult_req_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_par_inv(in_par_inv),
        .arg_a(arg_a), .arg_b(arg_b), .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity),
        .req(req), .ack(ack), .result(result), .result_parity(result_parity),
        .arg_parity_error(arg_parity_error), .result_rdy(result_rdy),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_status(res_status),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected response from the block's rules: timeout, then arg parity, then result parity.
    function automatic logic [33:0] expect_res(input txn_t t);
        logic signed [31:0] p;
        p = $signed(t.a) * $signed(t.b);
        if (t.mode == M_NOACK) return {2'b11, 32'h0};
        if (t.inv != 2'b00)    return {2'b01, 32'h0};
        if (t.mode == M_BADPAR) return {2'b10, p};
        return {2'b00, p};
    endfunction

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] inv, input int mode);
        txn_t t;
        int w;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_par_inv = inv;
        w = 0;
        while (!in_ready && w < 2000) begin @(negedge clk); w++; end
        if (!in_ready) begin
            chk("push_accept", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            t = '{a, b, inv, mode};
            arg_q.push_back(t);
            res_q.push_back(expect_res(t));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while ((res_q.size() != 0 || busy) && w < limit) begin @(negedge clk); w++; end
        chk("drain_pending", res_q.size(), 0);
    endtask

    task automatic wait_req(input logic lvl);
        int w;
        w = 0;
        while (req !== lvl && w < 100) begin @(negedge clk); w++; end
        chk("wait_req", req, lvl);
    endtask

    // Result-stream ready, changed just after the rising edge.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a handshake visible here completes on the next rising edge.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (res_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_result: got %0h status %0h, expected none", res_data, res_status);
                end else begin
                    e = res_q.pop_front();
                    chk("res_data", res_data, e[31:0]);
                    chk("res_status", res_status, e[33:32]);
                    last_data = res_data; last_status = res_status; n_res++;
                end
            end
        end
    end

    // Behavioural multiplier: checks the issued args, then acks and returns a product.
    txn_t        m_t;
    int          m_n, m_ad, m_rd;
    logic        m_pe;
    logic signed [31:0] m_rr;
    initial begin
        ack = 0; result_rdy = 0; result = '0; result_parity = 0; arg_parity_error = 0;
        forever begin
            @(negedge clk);
            if (!rst && req) begin
                if (arg_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_req: got req=1, expected 0");
                    m_n = 0;
                    while (req && m_n < 1000) begin @(negedge clk); m_n++; end
                end else begin
                    m_t = arg_q.pop_front();
                    chk("arg_a", arg_a, m_t.a);
                    chk("arg_b", arg_b, m_t.b);
                    chk("arg_a_parity", arg_a_parity, ^m_t.a ^ m_t.inv[0]);
                    chk("arg_b_parity", arg_b_parity, ^m_t.b ^ m_t.inv[1]);
                    m_pe = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
                    m_rr = m_pe ? 32'sd0 : $signed(arg_a) * $signed(arg_b);
                    if (m_t.mode == M_NOACK) begin
                        m_n = 1;
                        while (req && !rst && m_n < 1000) begin
                            @(negedge clk);
                            if (req) m_n++;
                        end
                        req_len = m_n;
                        if (!rst) begin
                            @(negedge clk);
                            ack = 1; result_rdy = 1; result = 32'h1234; result_parity = 0;
                            @(negedge clk);
                            ack = 0; result_rdy = 0;
                        end
                    end else begin
                        m_ad = (m_t.mode == M_SLOW) ? 1 : int'($urandom_range(0, 3));
                        m_rd = (m_t.mode == M_SLOW) ? 30 : int'($urandom_range(0, 4));
                        for (int i = 0; i < m_ad && !rst; i++) @(negedge clk);
                        if (!rst) begin
                            ack = 1;
                            result = m_rr; arg_parity_error = m_pe;
                            result_parity = ^m_rr ^ (m_t.mode == M_BADPAR);
                            if (m_rd == 0) result_rdy = 1;
                            @(negedge clk);
                            ack = 0; result_rdy = 0;
                            if (m_rd > 0) begin
                                for (int i = 0; i < m_rd - 1 && !rst; i++) @(negedge clk);
                                if (!rst) begin
                                    result_rdy = 1;
                                    @(negedge clk);
                                    result_rdy = 0;
                                end
                            end
                        end
                    end
                    ack = 0; result_rdy = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int base;
        rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_par_inv = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_args", {arg_a, arg_b, arg_a_parity, arg_b_parity}, 0);
        chk("rst_res", {res_data, res_status}, 0);
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Basic product 3 * -5
        push(16'd3, 16'hFFFB, 2'b00, M_OK);
        idle();
        wait_req(1'b1);
        chk("basic_par_a", arg_a_parity, 0);
        chk("basic_par_b", arg_b_parity, 1);
        drain(200);
        chk("basic_data", last_data, 32'hFFFFFFF1);
        chk("basic_status", last_status, 2'b00);

        // Marginal values back to back
        base = n_res;
        push(16'h7FFF, 16'h7FFF, 2'b00, M_OK);
        push(16'h8FFF, 16'h8FFF, 2'b00, M_OK);
        idle();
        drain(300);
        chk("marg_count", n_res - base, 2);
        chk("marg_data", last_data, 32'h3100E001);

        // Inverted arg parity
        push(16'h1234, 16'h0001, 2'b01, M_OK);
        idle(); drain(200);
        chk("argerr_a_status", last_status, 2'b01);
        chk("argerr_a_data", last_data, 0);
        push(16'h1234, 16'h0001, 2'b11, M_OK);
        idle(); drain(200);
        chk("argerr_ab_status", last_status, 2'b01);

        // Result parity mismatch
        push(16'd3, 16'd1, 2'b00, M_BADPAR);
        idle(); drain(200);
        chk("rpar_status", last_status, 2'b10);
        chk("rpar_data", last_data, 32'h3);

        // Timeout, then a stray ack/result_rdy
        push(16'd5, 16'd7, 2'b00, M_NOACK);
        idle(); drain(1000);
        base = n_res;
        repeat (10) @(negedge clk);
        chk("to_req_len", req_len, 255);
        chk("to_status", last_status, 2'b11);
        chk("to_data", last_data, 0);
        chk("to_no_stray", n_res - base, 0);

        // Randomized mix with random result backpressure
        rr_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push(16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 ($urandom_range(0, 4) == 0) ? M_BADPAR : M_OK);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        idle();
        drain(5000);

        // Backpressure: 1 in flight plus 4 buffered fills the FIFO
        rr_mode = 0;
        repeat (2) @(negedge clk);
        base = n_res;
        for (int i = 0; i < 5; i++) push(16'(i + 1), 16'(100 * i - 7), 2'b00, M_OK);
        idle();
        repeat (10) @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        rr_mode = 1;
        push(16'h0102, 16'hFF00, 2'b00, M_OK);
        idle(); drain(1000);
        chk("bp_count", n_res - base, 6);

        // Reset while waiting for the result, with entries buffered
        push(16'd11, 16'd13, 2'b00, M_SLOW);
        push(16'd2, 16'd2, 2'b00, M_OK);
        push(16'd4, 16'd4, 2'b00, M_OK);
        idle();
        wait_req(1'b1);
        wait_req(1'b0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        arg_q.delete();
        res_q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        push(16'd100, 16'hFFFD, 2'b00, M_OK);
        idle(); drain(200);
        chk("post_rst_data", last_data, 32'hFFFFFED4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
